// File: rtl/saturation_correction_mult_pipe.sv
// saturation_correction_mult_pipe: per-channel Ac*Jc product scaled to a rounded, clamped pixel
// through a 3-stage valid/ready pipeline, with per-channel clamp flags and a saturating clamp counter.
module saturation_correction_mult_pipe #(
  parameter int CHANNELS = 3,
  parameter int A_W      = 10,
  parameter int A_FRAC   = 7,
  parameter int J_W      = 10,
  parameter int J_FRAC   = 4,
  parameter int OUT_W    = 8,
  parameter int ROUND    = 1,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      bypass,
  input  logic [CHANNELS*A_W-1:0]   ac_in,
  input  logic [CHANNELS*J_W-1:0]   jc_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*OUT_W-1:0] pix_out,
  output logic [CHANNELS-1:0]       sat_flags,
  input  logic                      sat_clr,
  output logic [CNT_W-1:0]          sat_count
);
  localparam int SH  = A_FRAC + J_FRAC;
  localparam int PW  = A_W + J_W;
  localparam int PCW = $clog2(CHANNELS + 1);
  localparam logic [PW:0] RND = (ROUND != 0) ? (PW+1)'(1) << (SH - 1) : '0;

  if (SH < 1 || OUT_W > PW - SH + 1) begin : g_illegal
    $error("saturation_correction_mult_pipe: illegal SH/OUT_W combination");
  end

  logic                      en;
  logic                      v1_q, v2_q, v3_q, byp1_q;
  logic [CHANNELS*A_W-1:0]   ac1_q;
  logic [CHANNELS*J_W-1:0]   jc1_q;
  logic [CHANNELS*PW-1:0]    p2_q, p2_d;
  logic [CHANNELS*OUT_W-1:0] pix_q, pix_d;
  logic [CHANNELS-1:0]       sat_q, sat_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [PCW-1:0]            pop;
  logic [CNT_W:0]            sum;

  assign en        = !v3_q || out_ready;
  assign in_ready  = en;
  assign out_valid = v3_q;
  assign pix_out   = pix_q;
  assign sat_flags = sat_q;
  assign sat_count = cnt_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [A_W-1:0] a;
    logic [J_W-1:0] j;
    logic [PW:0]    r;
    assign a = ac1_q[c*A_W +: A_W];
    assign j = jc1_q[c*J_W +: J_W];
    // bypass shifts Jc by A_FRAC so both paths share the same binary point
    assign p2_d[c*PW +: PW] = byp1_q ? PW'(j) << A_FRAC : PW'(a) * PW'(j);
    assign r = ({1'b0, p2_q[c*PW +: PW]} + RND) >> SH;
    assign sat_d[c] = |r[PW:OUT_W];
    assign pix_d[c*OUT_W +: OUT_W] = sat_d[c] ? '1 : r[OUT_W-1:0];
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < CHANNELS; i++) pop = pop + PCW'(sat_q[i]);
    sum   = {1'b0, cnt_q} + (CNT_W+1)'(pop);
    cnt_d = sat_clr ? '0 : (v3_q && out_ready) ? (sum[CNT_W] ? '1 : sum[CNT_W-1:0]) : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      byp1_q <= 1'b0;
      ac1_q  <= '0;
      jc1_q  <= '0;
      p2_q   <= '0;
      pix_q  <= '0;
      sat_q  <= '0;
    end else if (en) begin
      v1_q   <= in_valid;
      byp1_q <= bypass;
      ac1_q  <= ac_in;
      jc1_q  <= jc_in;
      v2_q   <= v1_q;
      p2_q   <= p2_d;
      v3_q   <= v2_q;
      pix_q  <= pix_d;
      sat_q  <= sat_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: tb/tb_saturation_correction_mult_pipe.sv
// tb_saturation_correction_mult_pipe: rounding and truncating builds driven in parallel,
// checked against an arithmetic model of the pixel scaling and a queue-based scoreboard.
`timescale 1ns/1ps
module tb_saturation_correction_mult_pipe;
  localparam int CH = 3, AW = 10, JW = 10, OW = 8, CW = 16;
  localparam longint SCALE = 2048, HALF = 1024, PMAX = 255, CMAX = 65535;

  typedef struct packed {
    logic [CH*OW-1:0] pix;
    logic [CH-1:0]    flg;
    logic [CH*OW-1:0] pix0;
    logic [CH-1:0]    flg0;
  } beat_t;

  logic clk = 1'b0, rst_n = 1'b1, in_valid = 1'b0, bypass = 1'b0, out_ready = 1'b1, sat_clr = 1'b0;
  logic [CH*AW-1:0] ac_in = '0;
  logic [CH*JW-1:0] jc_in = '0;
  logic in_ready, out_valid, in_ready0, out_valid0;
  logic [CH*OW-1:0] pix_out, pix0;
  logic [CH-1:0] sat_flags, flg0;
  logic [CW-1:0] sat_count, cnt0;

  beat_t exp_q[$], obs_q[$];
  int checks = 0, errors = 0;
  int cnt_exp = 0, cnt0_exp = 0;

  always #5 clk = ~clk;

  saturation_correction_mult_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .bypass(bypass),
    .ac_in(ac_in), .jc_in(jc_in), .out_valid(out_valid), .out_ready(out_ready),
    .pix_out(pix_out), .sat_flags(sat_flags), .sat_clr(sat_clr), .sat_count(sat_count));

  saturation_correction_mult_pipe #(.ROUND(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .bypass(bypass),
    .ac_in(ac_in), .jc_in(jc_in), .out_valid(out_valid0), .out_ready(out_ready),
    .pix_out(pix0), .sat_flags(flg0), .sat_clr(sat_clr), .sat_count(cnt0));

  function automatic beat_t model(input logic [CH*AW-1:0] ac, input logic [CH*JW-1:0] jc, input logic byp);
    beat_t b;
    for (int c = 0; c < CH; c++) begin
      longint a, j, p, r1, r0;
      a  = longint'(ac[c*AW +: AW]);
      j  = longint'(jc[c*JW +: JW]);
      p  = byp ? j * 128 : a * j;
      r1 = (p + HALF) / SCALE;
      r0 = p / SCALE;
      b.pix[c*OW +: OW]  = (r1 > PMAX) ? 8'hFF : r1[7:0];
      b.flg[c]           = r1 > PMAX;
      b.pix0[c*OW +: OW] = (r0 > PMAX) ? 8'hFF : r0[7:0];
      b.flg0[c]          = r0 > PMAX;
    end
    return b;
  endfunction

  function automatic int sat_add(input int cur, input int n);
    return (cur + n > CMAX) ? int'(CMAX) : cur + n;
  endfunction

  // inputs change only at posedge+1, so negedge sees exactly what the next edge will sample
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) exp_q.push_back(model(ac_in, jc_in, bypass));
    if (rst_n && out_valid && out_ready) obs_q.push_back('{pix_out, sat_flags, pix0, flg0});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [CH*AW-1:0] a, input logic [CH*JW-1:0] j, input logic b);
    logic acc;
    acc = 1'b0;
    ac_in = a; jc_in = j; bypass = b; in_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (6) step();
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    in_valid = 1'b1; ac_in = '1; jc_in = '1; out_ready = 1'b1;
    repeat (3) step();
    checks++; if (out_valid !== 1'b0 || out_valid0 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b/%b want 0", out_valid, out_valid0); end
    checks++; if (pix_out !== '0 || pix0 !== '0) begin errors++; $display("FAIL reset_pix: got %h/%h want 0", pix_out, pix0); end
    checks++; if (sat_flags !== '0 || flg0 !== '0) begin errors++; $display("FAIL reset_flags: got %b/%b want 0", sat_flags, flg0); end
    checks++; if (sat_count !== '0 || cnt0 !== '0) begin errors++; $display("FAIL reset_count: got %0d/%0d want 0", sat_count, cnt0); end
    in_valid = 1'b0;
    rst_n = 1'b1;
    repeat (5) step();
    checks++; if (obs_q.size() !== 0 || out_valid !== 1'b0) begin errors++; $display("FAIL reset_no_beat: got %0d beats want 0", obs_q.size()); end
  endtask

  task automatic test_latency();
    beat_t e, o;
    out_ready = 1'b1;
    ac_in = {3{10'd128}}; jc_in = {3{10'd640}}; bypass = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_edge1: got %b want 0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_edge2: got %b want 0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b1 || out_valid0 !== 1'b1) begin errors++; $display("FAIL latency_edge3: got %b/%b want 1", out_valid, out_valid0); end
    checks++; if (pix_out !== {3{8'd40}} || sat_flags !== 3'b000) begin errors++; $display("FAIL latency_pix: got %h flags %b want 282828 flags 000", pix_out, sat_flags); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_single: got %b want 0", out_valid); end
    checks++; if (obs_q.size() !== 1 || exp_q.size() !== 1) begin errors++; $display("FAIL latency_count: got %0d/%0d want 1", obs_q.size(), exp_q.size()); end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL latency_beat: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_directed();
    beat_t want[3], o;
    want[0] = '{{8'd255, 8'd2, 8'd40}, 3'b100, {8'd255, 8'd1, 8'd40}, 3'b000};
    want[1] = '{{8'd0, 8'd0, 8'd255}, 3'b001, {8'd0, 8'd0, 8'd255}, 3'b001};
    want[2] = '{{8'd64, 8'd1, 8'd64}, 3'b000, {8'd63, 8'd1, 8'd63}, 3'b000};
    out_ready = 1'b1;
    send({10'd1022, 10'd192, 10'd128}, {10'd512, 10'd16, 10'd640}, 1'b0);
    send({10'd1, 10'd0, 10'd1023}, {10'd1, 10'd0, 10'd1023}, 1'b0);
    send({10'd7, 10'd5, 10'd0}, {10'd1023, 10'd16, 10'h3F8}, 1'b1);
    drain();
    checks++; if (obs_q.size() !== 3) begin errors++; $display("FAIL directed_count: got %0d want 3", obs_q.size()); end
    for (int i = 0; i < 3 && obs_q.size() != 0; i++) begin
      o = obs_q.pop_front();
      checks++; if (o !== want[i]) begin errors++; $display("FAIL directed_beat%0d: got %h want %h", i, o, want[i]); end
      cnt_exp = sat_add(cnt_exp, $countones(want[i].flg));
      cnt0_exp = sat_add(cnt0_exp, $countones(want[i].flg0));
    end
    exp_q.delete(); obs_q.delete();
    checks++; if (sat_count !== CW'(cnt_exp) || cnt0 !== CW'(cnt0_exp)) begin errors++; $display("FAIL directed_satcount: got %0d/%0d want %0d/%0d", sat_count, cnt0, cnt_exp, cnt0_exp); end
  endtask

  task automatic test_random(input int n);
    int sent;
    beat_t e, o;
    sent = 0;
    for (int t = 0; t < 20 * n && sent < n; t++) begin
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 9) < 7;
      bypass = $urandom_range(0, 3) == 0;
      for (int c = 0; c < CH; c++) begin
        ac_in[c*AW +: AW] = AW'($urandom_range(0, 1023));
        jc_in[c*JW +: JW] = JW'($urandom_range(0, 1023));
      end
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      step();
    end
    drain();
    checks++; if (obs_q.size() !== n || exp_q.size() !== n) begin errors++; $display("FAIL random_count: got %0d/%0d want %0d", obs_q.size(), exp_q.size(), n); end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL random_beat: got %h want %h", o, e); end
      cnt_exp = sat_add(cnt_exp, $countones(e.flg));
      cnt0_exp = sat_add(cnt0_exp, $countones(e.flg0));
    end
    exp_q.delete(); obs_q.delete();
    checks++; if (sat_count !== CW'(cnt_exp) || cnt0 !== CW'(cnt0_exp)) begin errors++; $display("FAIL random_satcount: got %0d/%0d want %0d/%0d", sat_count, cnt0, cnt_exp, cnt0_exp); end
  endtask

  task automatic test_stall();
    int sent;
    logic [CH*OW-1:0] held;
    beat_t e, o;
    sent = 0;
    held = '0;
    for (int t = 0; t < 40 && (sent < 10 || t < 10); t++) begin
      out_ready = !(t >= 5 && t < 9);
      in_valid = sent < 10;
      bypass = 1'b0;
      for (int c = 0; c < CH; c++) begin
        ac_in[c*AW +: AW] = AW'($urandom_range(100, 400));
        jc_in[c*JW +: JW] = JW'($urandom_range(0, 1023));
      end
      @(negedge clk);
      if (t == 5) held = pix_out;
      if (t >= 5 && t < 9) begin
        checks++; if (in_ready !== 1'b0 || in_ready0 !== 1'b0) begin errors++; $display("FAIL stall_in_ready t=%0d: got %b/%b want 0", t, in_ready, in_ready0); end
        checks++; if (out_valid !== 1'b1 || pix_out !== held) begin errors++; $display("FAIL stall_hold t=%0d: got v=%b pix=%h want v=1 pix=%h", t, out_valid, pix_out, held); end
      end
      if (in_valid && in_ready) sent++;
      step();
    end
    drain();
    checks++; if (sent !== 10 || obs_q.size() !== 10 || exp_q.size() !== 10) begin errors++; $display("FAIL stall_count: got sent=%0d obs=%0d exp=%0d want 10", sent, obs_q.size(), exp_q.size()); end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL stall_beat: got %h want %h", o, e); end
      cnt_exp = sat_add(cnt_exp, $countones(e.flg));
      cnt0_exp = sat_add(cnt0_exp, $countones(e.flg0));
    end
    exp_q.delete(); obs_q.delete();
    checks++; if (sat_count !== CW'(cnt_exp)) begin errors++; $display("FAIL stall_satcount: got %0d want %0d", sat_count, cnt_exp); end
  endtask

  task automatic test_reset_midstream();
    beat_t e, o;
    out_ready = 1'b0;
    send({10'd200, 10'd300, 10'd400}, {10'd50, 10'd60, 10'd70}, 1'b0);
    send({10'd1023, 10'd1023, 10'd1023}, {10'd1023, 10'd1023, 10'd1023}, 1'b0);
    send({10'd10, 10'd20, 10'd30}, {10'd40, 10'd50, 10'd60}, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_valid0 !== 1'b0) begin errors++; $display("FAIL midreset_out_valid: got %b/%b want 0", out_valid, out_valid0); end
    checks++; if (pix_out !== '0 || sat_flags !== '0 || sat_count !== '0) begin errors++; $display("FAIL midreset_outputs: got pix=%h flags=%b cnt=%0d want 0", pix_out, sat_flags, sat_count); end
    exp_q.delete(); obs_q.delete();
    cnt_exp = 0; cnt0_exp = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) step();
    checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL midreset_flushed: got %0d beats want 0", obs_q.size()); end
    for (int k = 0; k < 3; k++) begin
      sat_clr = (k == 1);
      send({3{10'd1023}}, {3{10'd1023}}, 1'b0);
      drain();
      sat_clr = 1'b0;
      while (exp_q.size() != 0 && obs_q.size() != 0) begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        checks++; if (o !== e) begin errors++; $display("FAIL clr_beat%0d: got %h want %h", k, o, e); end
        cnt_exp = (k == 1) ? 0 : sat_add(cnt_exp, $countones(e.flg));
        cnt0_exp = (k == 1) ? 0 : sat_add(cnt0_exp, $countones(e.flg0));
      end
      exp_q.delete(); obs_q.delete();
      checks++; if (sat_count !== CW'(cnt_exp) || cnt0 !== CW'(cnt0_exp)) begin errors++; $display("FAIL clr_satcount%0d: got %0d/%0d want %0d/%0d", k, sat_count, cnt0, cnt_exp, cnt0_exp); end
    end
    checks++; if (sat_count !== 16'd3) begin errors++; $display("FAIL clr_final: got %0d want 3", sat_count); end
  endtask

  task automatic test_count_saturate();
    int n;
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    for (int i = 0; i < 21844; i++) send({3{10'd1023}}, {3{10'd1023}}, 1'b0);
    drain();
    n = obs_q.size();
    exp_q.delete(); obs_q.delete();
    checks++; if (n !== 21844 || sat_count !== 16'd65532 || cnt0 !== 16'd65532) begin errors++; $display("FAIL cnt_near_max: got beats=%0d cnt=%0d/%0d want 21844 65532", n, sat_count, cnt0); end
    send({3{10'd1023}}, {3{10'd1023}}, 1'b0);
    drain();
    checks++; if (sat_count !== 16'hFFFF || cnt0 !== 16'hFFFF) begin errors++; $display("FAIL cnt_reach_max: got %0d/%0d want 65535", sat_count, cnt0); end
    send({3{10'd1023}}, {3{10'd1023}}, 1'b0);
    drain();
    checks++; if (sat_count !== 16'hFFFF || cnt0 !== 16'hFFFF) begin errors++; $display("FAIL cnt_sticky: got %0d/%0d want 65535", sat_count, cnt0); end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency();
    test_directed();
    test_random(200);
    test_stall();
    test_reset_midstream();
    test_count_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
